tank_sprite_fetch: RTL and testbench
====================================

Name: tank_sprite_fetch

Overview:
- Upstream address-generation and compositing stage for the tank sprite ROM/palette block.
- Maps the current VGA draw coordinate onto a 32x32 up-facing tank sprite and rotates it by address transform, so all four directions share one ROM.
- Drives rom_address and the enemy select, realigns the returned 4-bit RGB with the ROM latency, and emits a registered pixel plus an opaque flag to the frame compositor.
- Tank position, direction and alive state are latched once per frame, which prevents tearing.

Parameters:
- SPRITE_SIZE, 32, sprite width = height in pixels (power of two; square so rotation is valid)
- ADDR_W, 10, ROM address width; equals 2*log2(SPRITE_SIZE)
- ROM_LAT, 1, clocks from rom_address to valid red/green/blue at the ROM block outputs
- KEY_RGB, 12'h000, {r,g,b} colour treated as transparent
- BLINK_FRAMES, 120, spawn-blink duration in frames (BLINK_EN only)

Ports:
- clk  in  1  pixel clock
- reset_n  in  1  asynchronous active-low reset
- frame_start  in  1  one-cycle pulse at start of vertical blank
- pix_valid  in  1  draw_x/draw_y are an active-video pixel
- draw_x  in  10  current pixel column
- draw_y  in  10  current pixel row
- tank_x  in  10  tank top-left column, sampled on frame_start
- tank_y  in  10  tank top-left row, sampled on frame_start
- tank_dir  in  2  0=up 1=right 2=down 3=left, sampled on frame_start
- tank_alive  in  1  draw enable, sampled on frame_start
- tank_enemy  in  1  palette select, sampled on frame_start
- spawn  in  1  one-cycle pulse, starts blink (BLINK_EN only; ignored otherwise)
- rom_address  out  ADDR_W  registered address to sprite ROM block
- enemy  out  1  registered latched tank_enemy to ROM block
- rom_red, rom_green, rom_blue  in  4 each  colour returned by ROM block
- out_valid  out  1  pixel pipeline valid (delayed pix_valid)
- out_opaque  out  1  tank pixel present and not KEY_RGB
- out_red, out_green, out_blue  out  4 each  tank colour, 0 when not opaque

Behaviour:
- Reset: all outputs 0; latched x/y/dir/alive/enemy = 0; pipeline valids cleared. After reset, no tank is drawn until the first frame_start.
- Latch on frame_start: registers take tank_x/y/dir/alive/enemy. A pixel presented in the same cycle as frame_start uses the old latched values.
- Stage A, cycle N, combinational:
  - dx = {1'b0,draw_x} - {1'b0,tank_x} in 11 bits; dy likewise.
  - hit = pix_valid & alive & dx,dy both in [0, SPRITE_SIZE-1]. Negative differences never hit; tank_x up to 1023 must not wrap.
- Address transform, with lx = dx[4:0], ly = dy[4:0], M = SPRITE_SIZE-1, addr = row*SPRITE_SIZE + col:
  - up: row ly, col lx
  - right: row M-lx, col ly
  - down: row M-ly, col M-lx
  - left: row lx, col M-ly
- Cycle N+1: rom_address, hit_d and valid_d registered. When hit=0, rom_address holds its previous value.
- Cycle N+1+ROM_LAT: rom_* are valid. A shift register of depth ROM_LAT carries hit and valid to this point.
- Cycle N+2+ROM_LAT: out_* registered.
  - out_opaque = hit_pipe & ({rom_red,rom_green,rom_blue} != KEY_RGB).
  - out_red/green/blue = rom_* if out_opaque, else 0.
  - out_valid = delayed pix_valid.
  - Total latency: 3 clocks at ROM_LAT=1.
- Pipeline: fully pipelined, one pixel per clock, no stall or backpressure.
- enemy output is the latched flag; it changes only at frame_start.
- Reset asserted mid-frame: pipeline flushes immediately (async), and out_opaque = 0 on the next edge after release.

Optional Feature:
- Macro: TANK_SPAWN_BLINK_EN.
- Defined:
  - 7-bit frame counter loaded with BLINK_FRAMES on spawn and decremented on each frame_start while nonzero.
  - While nonzero, alive is forced to 0 in frames where counter[3]=1, giving an 8-frame on/off blink.
  - spawn coincident with frame_start: the load wins.
  - Counter reset value 0.
- Undefined: the counter logic is absent, spawn is unused, and behaviour is exactly as above.

Test Plan:
- Reset, then frame_start with tank_x=100, tank_y=50, dir=0, alive=1. Pixel (100,50) gives rom_address=0; pixel (131,81) gives 1023. out_opaque follows rom_* 3 clocks later; (99,50) and (132,50) give out_opaque=0.
- dir=1 at tank (0,0): pixel (0,0) gives rom_address=992 and pixel (31,0) gives 0. dir=2: (0,0) gives 1023. dir=3: (0,0) gives 31.
- tank_x=1010: pixel (1020,y) hits; pixel (5,y) does not hit (no wrap). pix_valid=0 always gives out_opaque=0, out_valid=0.
- rom_* = 12'h000 on a hit gives out_opaque=0 and rgb 0. rom_* = 12'hF80 gives out_opaque=1 and out_red=F, out_green=8, out_blue=0.
- Change tank_x mid-frame: rendered position is unchanged until the next frame_start. A pixel in the same cycle as frame_start uses the old position. Assert reset_n=0 mid-line: all outputs read 0 asynchronously.
- With TANK_SPAWN_BLINK_EN, BLINK_FRAMES=120: spawn gives the tank drawn in frames 1-8, hidden in frames 9-16, and so on; steady visible after 120 frames.

Source files
------------

// File: rtl/tank_sprite_fetch.sv
// -----------------------------------------------------------------------------
// tank_sprite_fetch
//
// Upstream address-generation and compositing stage for the tank sprite
// ROM/palette block. Each draw coordinate is mapped onto a 32x32 up-facing
// tank sprite. The sprite is rotated by transforming the ROM address, so all
// four facing directions read from one ROM. The returned colour is realigned
// with the ROM latency, and the block emits a registered pixel plus an opaque
// flag for the frame compositor.
//
// Tank position, direction, alive and enemy are latched on frame_start.
// A whole frame therefore renders from one consistent snapshot.
//
// Optional feature macro: TANK_SPAWN_BLINK_EN
//   When defined, a spawn pulse starts a BLINK_FRAMES-long blink. During the
//   blink the tank is hidden in every frame where counter bit 3 is set, which
//   gives 8 frames on and 8 frames off. When undefined, spawn is ignored.
//
// Ports:
//   clk                    in   pixel clock
//   reset_n                in   asynchronous active-low reset
//   frame_start            in   one-cycle pulse at start of vertical blank
//   pix_valid              in   draw_x/draw_y is an active-video pixel
//   draw_x, draw_y         in   current pixel column / row (10b)
//   tank_x, tank_y         in   tank top-left, sampled on frame_start (10b)
//   tank_dir               in   0=up 1=right 2=down 3=left, sampled on frame_start
//   tank_alive             in   draw enable, sampled on frame_start
//   tank_enemy             in   palette select, sampled on frame_start
//   spawn                  in   blink start pulse (blink build only)
//   rom_address            out  registered sprite ROM address (ADDR_W)
//   enemy                  out  latched palette select to the ROM block
//   rom_red/green/blue     in   colour returned by the ROM block (4b each)
//   out_valid              out  delayed pix_valid
//   out_opaque             out  tank pixel present and not KEY_RGB
//   out_red/green/blue     out  tank colour, 0 when not opaque (4b each)
// -----------------------------------------------------------------------------
module tank_sprite_fetch #(
   parameter int          SPRITE_SIZE  = 32,
   parameter int          ADDR_W       = 10,
   parameter int          ROM_LAT      = 1,
   parameter logic [11:0] KEY_RGB      = 12'h000,
   parameter int          BLINK_FRAMES = 120
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              frame_start,
   input  logic              pix_valid,
   input  logic [9:0]        draw_x,
   input  logic [9:0]        draw_y,
   input  logic [9:0]        tank_x,
   input  logic [9:0]        tank_y,
   input  logic [1:0]        tank_dir,
   input  logic              tank_alive,
   input  logic              tank_enemy,
   input  logic              spawn,
   output logic [ADDR_W-1:0] rom_address,
   output logic              enemy,
   input  logic [3:0]        rom_red,
   input  logic [3:0]        rom_green,
   input  logic [3:0]        rom_blue,
   output logic              out_valid,
   output logic              out_opaque,
   output logic [3:0]        out_red,
   output logic [3:0]        out_green,
   output logic [3:0]        out_blue
);

   localparam int             LW = $clog2(SPRITE_SIZE);
   localparam logic [LW-1:0]  M  = LW'(SPRITE_SIZE - 1);

   // Per-frame snapshot of the tank state.
   logic [9:0]    x_r;
   logic [9:0]    y_r;
   logic [1:0]    dir_r;
   logic          alive_r;
   logic          blink_hide_s;

   // Stage A signals.
   logic [10:0]   dx_s;
   logic [10:0]   dy_s;
   logic [LW-1:0] lx_s;
   logic [LW-1:0] ly_s;
   logic [LW-1:0] row_s;
   logic [LW-1:0] col_s;
   logic          hit_s;

   // Hit/valid delay line. Index 0 is the stage registered together with
   // rom_address. Index ROM_LAT lines up with the ROM data.
   logic [ROM_LAT:0] hit_sr_r;
   logic [ROM_LAT:0] valid_sr_r;

   logic [11:0]   rom_rgb_s;
   logic          opaque_s;

`ifdef TANK_SPAWN_BLINK_EN
   logic [6:0] blink_cnt_r;
   logic [6:0] blink_cnt_next_s;

   // Blink counter next value: spawn load wins over the per-frame decrement.
   always_comb begin
      blink_cnt_next_s = blink_cnt_r;
      if (spawn) begin
         blink_cnt_next_s = 7'(BLINK_FRAMES);
      end else if (frame_start && (blink_cnt_r != 7'd0)) begin
         blink_cnt_next_s = blink_cnt_r - 7'd1;
      end else begin
         blink_cnt_next_s = blink_cnt_r;
      end
   end

   // Blink counter register.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         blink_cnt_r <= 7'd0;
      end else begin
         blink_cnt_r <= blink_cnt_next_s;
      end
   end

   // Visibility is decided from the count that the new frame starts with.
   assign blink_hide_s = (blink_cnt_next_s != 7'd0) & blink_cnt_next_s[3];
`else
   logic spawn_unused_s;
   localparam int blink_frames_unused = BLINK_FRAMES;
   assign spawn_unused_s = spawn;
   assign blink_hide_s   = 1'b0;
`endif

   // Tank state snapshot, taken once per frame.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         x_r     <= 10'd0;
         y_r     <= 10'd0;
         dir_r   <= 2'd0;
         alive_r <= 1'b0;
         enemy   <= 1'b0;
      end else if (frame_start) begin
         x_r     <= tank_x;
         y_r     <= tank_y;
         dir_r   <= tank_dir;
         alive_r <= tank_alive & ~blink_hide_s;
         enemy   <= tank_enemy;
      end
   end

   // The differences are 11 bits wide, so a pixel left of or above the tank
   // sets bit 10 and can never alias into the sprite. No wrap at x = 1023.
   assign dx_s = {1'b0, draw_x} - {1'b0, x_r};
   assign dy_s = {1'b0, draw_y} - {1'b0, y_r};
   assign lx_s = dx_s[LW-1:0];
   assign ly_s = dy_s[LW-1:0];
   assign hit_s = pix_valid & alive_r
                & (dx_s[10:LW] == {(11-LW){1'b0}})
                & (dy_s[10:LW] == {(11-LW){1'b0}});

   // Rotation of the up-facing sprite via row/column remapping.
   always_comb begin
      row_s = ly_s;
      col_s = lx_s;
      case (dir_r)
         2'd0: begin row_s = ly_s;        col_s = lx_s;        end
         2'd1: begin row_s = M - lx_s;    col_s = ly_s;        end
         2'd2: begin row_s = M - ly_s;    col_s = M - lx_s;    end
         2'd3: begin row_s = lx_s;        col_s = M - ly_s;    end
         default: begin row_s = ly_s;     col_s = lx_s;        end
      endcase
   end

   // ROM address: holds its last value on non-hit pixels to avoid toggling.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         rom_address <= {ADDR_W{1'b0}};
      end else if (hit_s) begin
         rom_address <= ADDR_W'({row_s, col_s});
      end
   end

   // Hit/valid delay line matching the ROM read latency.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         hit_sr_r   <= {(ROM_LAT+1){1'b0}};
         valid_sr_r <= {(ROM_LAT+1){1'b0}};
      end else begin
         hit_sr_r[0]   <= hit_s;
         valid_sr_r[0] <= pix_valid;
         for (int i = 1; i <= ROM_LAT; i++) begin
            hit_sr_r[i]   <= hit_sr_r[i-1];
            valid_sr_r[i] <= valid_sr_r[i-1];
         end
      end
   end

   assign rom_rgb_s = {rom_red, rom_green, rom_blue};
   assign opaque_s  = hit_sr_r[ROM_LAT] & (rom_rgb_s != KEY_RGB);

   // Registered compositor outputs. Colour is zeroed unless opaque.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         out_valid  <= 1'b0;
         out_opaque <= 1'b0;
         out_red    <= 4'd0;
         out_green  <= 4'd0;
         out_blue   <= 4'd0;
      end else begin
         out_valid  <= valid_sr_r[ROM_LAT];
         out_opaque <= opaque_s;
         out_red    <= opaque_s ? rom_red   : 4'd0;
         out_green  <= opaque_s ? rom_green : 4'd0;
         out_blue   <= opaque_s ? rom_blue  : 4'd0;
      end
   end

endmodule

// File: tb/tb_tank_sprite_fetch.sv
// -----------------------------------------------------------------------------
// Testbench for tank_sprite_fetch (default build, blink feature disabled).
// A behavioural ROM (one clock of latency) feeds the DUT. A reference model
// holds the tank state latched each frame and predicts three things: the ROM
// address, the enemy flag, and the output pixel three clocks after each input
// pixel.
// -----------------------------------------------------------------------------
module tb_tank_sprite_fetch;

   logic        clk = 1'b0;
   logic        reset_n;
   logic        frame_start;
   logic        pix_valid;
   logic [9:0]  draw_x, draw_y;
   logic [9:0]  tank_x, tank_y;
   logic [1:0]  tank_dir;
   logic        tank_alive, tank_enemy, spawn;
   logic [9:0]  rom_address;
   logic        enemy;
   logic [3:0]  rom_red, rom_green, rom_blue;
   logic        out_valid, out_opaque;
   logic [3:0]  out_red, out_green, out_blue;

   always #5 clk = ~clk;

   tank_sprite_fetch dut (
      .clk(clk), .reset_n(reset_n), .frame_start(frame_start),
      .pix_valid(pix_valid), .draw_x(draw_x), .draw_y(draw_y),
      .tank_x(tank_x), .tank_y(tank_y), .tank_dir(tank_dir),
      .tank_alive(tank_alive), .tank_enemy(tank_enemy), .spawn(spawn),
      .rom_address(rom_address), .enemy(enemy),
      .rom_red(rom_red), .rom_green(rom_green), .rom_blue(rom_blue),
      .out_valid(out_valid), .out_opaque(out_opaque),
      .out_red(out_red), .out_green(out_green), .out_blue(out_blue)
   );

   // Sprite ROM model: registered read, one clock latency.
   logic [11:0] rom_mem [0:1023];
   logic [11:0] rom_q;
   always @(posedge clk) rom_q <= rom_mem[rom_address];
   assign {rom_red, rom_green, rom_blue} = rom_q;

   typedef struct {
      logic        v;
      logic        o;
      logic [11:0] rgb;
   } exp_t;

   exp_t q[$];
   int   checks = 0;
   int   errors = 0;

   // Reference state: tank snapshot, and the last address issued on a hit.
   int   m_x, m_y, m_dir, m_addr;
   logic m_alive, m_enemy;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      checks++;
      assert (obs === exp_v) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
      end
   endtask

   // Sprite pixel (lx,ly) as seen by a tank facing 'dir'.
   // The result is the row-major index into the up-facing image.
   function automatic int sprite_addr(input int dir, input int lx, input int ly);
      int row, col;
      case (dir)
         0:       begin row = ly;      col = lx;      end
         1:       begin row = 31 - lx; col = ly;      end
         2:       begin row = 31 - ly; col = 31 - lx; end
         default: begin row = lx;      col = 31 - ly; end
      endcase
      return row * 32 + col;
   endfunction

   // Present one pixel (and optional frame_start) for one clock, then check.
   task automatic step(input logic pv, input int x, input int y, input logic fs);
      exp_t e;
      int   dx, dy;
      pix_valid   = pv;
      draw_x      = x[9:0];
      draw_y      = y[9:0];
      frame_start = fs;
      dx = x - m_x;
      dy = y - m_y;
      e.v = pv; e.o = 1'b0; e.rgb = 12'h000;
      if (pv && m_alive && dx >= 0 && dx < 32 && dy >= 0 && dy < 32) begin
         m_addr = sprite_addr(m_dir, dx, dy);
         if (rom_mem[m_addr] != 12'h000) begin
            e.o   = 1'b1;
            e.rgb = rom_mem[m_addr];
         end
      end
      q.push_back(e);
      if (fs) begin
         m_x = int'(tank_x); m_y = int'(tank_y); m_dir = int'(tank_dir);
         m_alive = tank_alive; m_enemy = tank_enemy;
      end
      @(posedge clk); #1;
      frame_start = 1'b0;
      pix_valid   = 1'b0;
      chk("rom_address", 32'(rom_address), 32'(m_addr));
      chk("enemy", 32'(enemy), 32'(m_enemy));
      if (q.size() >= 3) begin
         e = q.pop_front();
         chk("out_valid", 32'(out_valid), 32'(e.v));
         chk("out_opaque", 32'(out_opaque), 32'(e.o));
         chk("out_rgb", 32'({out_red, out_green, out_blue}), 32'(e.rgb));
      end
   endtask

   task automatic model_reset();
      q.delete();
      m_x = 0; m_y = 0; m_dir = 0; m_addr = 0;
      m_alive = 1'b0; m_enemy = 1'b0;
   endtask

   task automatic check_all_zero(input string tag);
      chk(tag, 32'({rom_address, enemy, out_valid, out_opaque, out_red, out_green, out_blue}), 32'd0);
   endtask

   initial begin
      int x, y;
      for (int i = 0; i < 1024; i++)
         rom_mem[i] = ($urandom_range(0, 3) == 0) ? 12'h000 : 12'($urandom);
      rom_mem[0]    = 12'hF80;
      rom_mem[1023] = 12'h000;

      reset_n = 1'b0; frame_start = 1'b0; pix_valid = 1'b0;
      draw_x = 10'd0; draw_y = 10'd0; tank_x = 10'd0; tank_y = 10'd0;
      tank_dir = 2'd0; tank_alive = 1'b0; tank_enemy = 1'b0; spawn = 1'b0;
      model_reset();
      repeat (3) @(posedge clk);
      #1;
      check_all_zero("reset_state");
      reset_n = 1'b1;

      // No tank before the first frame_start, even over the default position.
      step(1'b1, 0, 0, 1'b0);

      // Up-facing tank at (100,50): corner addresses and edge misses.
      tank_x = 10'd100; tank_y = 10'd50; tank_dir = 2'd0;
      tank_alive = 1'b1; tank_enemy = 1'b1;
      step(1'b0, 0, 0, 1'b1);
      step(1'b1, 100, 50, 1'b0);  chk("addr_up_first", 32'(rom_address), 32'd0);
      step(1'b1, 131, 81, 1'b0);  chk("addr_up_last", 32'(rom_address), 32'd1023);
      step(1'b1, 99, 50, 1'b0);
      step(1'b1, 132, 50, 1'b0);
      step(1'b0, 0, 0, 1'b0);
      step(1'b0, 0, 0, 1'b0);

      // Rotations at tank (0,0).
      tank_x = 10'd0; tank_y = 10'd0; tank_dir = 2'd1; tank_enemy = 1'b0;
      step(1'b0, 0, 0, 1'b1);
      step(1'b1, 0, 0, 1'b0);     chk("addr_right_00", 32'(rom_address), 32'd992);
      step(1'b1, 31, 0, 1'b0);    chk("addr_right_310", 32'(rom_address), 32'd0);
      tank_dir = 2'd2;
      step(1'b0, 0, 0, 1'b1);
      step(1'b1, 0, 0, 1'b0);     chk("addr_down_00", 32'(rom_address), 32'd1023);
      tank_dir = 2'd3;
      step(1'b0, 0, 0, 1'b1);
      step(1'b1, 0, 0, 1'b0);     chk("addr_left_00", 32'(rom_address), 32'd31);

      // Right screen edge: no wrap, and pix_valid=0 never draws.
      tank_x = 10'd1010; tank_y = 10'd10; tank_dir = 2'd0;
      step(1'b0, 0, 0, 1'b1);
      step(1'b1, 1020, 12, 1'b0);
      step(1'b1, 5, 12, 1'b0);
      step(1'b0, 1020, 12, 1'b0);
      step(1'b1, 1023, 41, 1'b0);

      // Mid-frame tank_x change is ignored until the next frame_start.
      tank_x = 10'd200; tank_y = 10'd50;
      step(1'b0, 0, 0, 1'b1);
      tank_x = 10'd300;
      step(1'b1, 200, 50, 1'b0);
      step(1'b1, 200, 51, 1'b1);  // same cycle as frame_start: old position
      step(1'b1, 200, 52, 1'b0);
      step(1'b1, 300, 52, 1'b0);

      // Randomised frames.
      for (int f = 0; f < 8; f++) begin
         tank_x = 10'($urandom_range(0, 1023));
         tank_y = 10'($urandom_range(0, 479));
         tank_dir = 2'($urandom_range(0, 3));
         tank_alive = ($urandom_range(0, 7) != 0);
         tank_enemy = 1'($urandom_range(0, 1));
         step(1'b0, 0, 0, 1'b1);
         for (int p = 0; p < 80; p++) begin
            x = int'(tank_x) + int'($urandom_range(0, 40)) - 4;
            y = int'(tank_y) + int'($urandom_range(0, 40)) - 4;
            if (x < 0) x = 0;
            if (x > 1023) x = 1023;
            if (y < 0) y = 0;
            if (y > 1023) y = 1023;
            if (p % 25 == 24) tank_x = 10'($urandom_range(0, 1023));
            step($urandom_range(0, 9) != 0, x, y, 1'b0);
         end
      end

      // Reset asserted mid-line: outputs clear immediately.
      tank_x = 10'd100; tank_y = 10'd50; tank_dir = 2'd0; tank_alive = 1'b1; tank_enemy = 1'b1;
      step(1'b0, 0, 0, 1'b1);
      step(1'b1, 100, 50, 1'b0);
      step(1'b1, 101, 50, 1'b0);
      step(1'b1, 102, 50, 1'b0);
      #2;
      reset_n = 1'b0;
      #1;
      check_all_zero("async_reset");
      model_reset();
      @(posedge clk); #1;
      reset_n = 1'b1;
      step(1'b1, 100, 50, 1'b0);
      step(1'b1, 0, 0, 1'b0);
      step(1'b1, 100, 50, 1'b0);
      step(1'b0, 0, 0, 1'b1);
      step(1'b1, 100, 50, 1'b0);
      step(1'b1, 110, 60, 1'b0);
      step(1'b0, 0, 0, 1'b0);
      step(1'b0, 0, 0, 1'b0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
